// File: rtl/downsampler_if.sv
// Pixel-stream and output-FIFO handshake bundle for the 2x2 decimator.
//   valid, sof, data     : input pixel stream (source -> decimator)
//   ready                : decimator can take a pixel this cycle
//   fifo_almost_full     : external output FIFO can absorb only one more write
//   fifo_write, dataout  : averaged pixel strobe and value toward the FIFO
// The master side is the surrounding environment (pixel source plus the
// output FIFO); the slave side is the decimator.
interface downsampler_if;
  logic       valid;
  logic       sof;
  logic [7:0] data;
  logic       ready;
  logic       fifo_almost_full;
  logic       fifo_write;
  logic [7:0] dataout;

  modport master (
    output valid, sof, data, fifo_almost_full,
    input  ready, fifo_write, dataout
  );

  modport slave (
    input  valid, sof, data, fifo_almost_full,
    output ready, fifo_write, dataout
  );
endinterface

// File: rtl/downsampler.sv
// 2x2 box-filter decimator. Takes an IN_WIDTH x IN_HEIGHT raster of 8-bit
// pixels and emits one rounded 2x2 average per output pixel into an external
// FIFO. Even-row horizontal pair sums are parked in a single line buffer and
// combined with the matching odd-row pair when the block completes.
// Ports:
//   clock             single rising-edge clock
//   reset_n           asynchronous active-low reset
//   px                handshake bundle (slave side), see downsampler_if
//   current_rowcount  input row of the next expected pixel
//   current_colcount  input column of the next expected pixel
//   frame_done        one-cycle pulse alongside the last output pixel of a frame
module downsampler #(
  parameter int IN_WIDTH  = 800,
  parameter int IN_HEIGHT = 600
) (
  input  logic          clock,
  input  logic          reset_n,
  downsampler_if.slave  px,
  output logic [9:0]    current_rowcount,
  output logic [9:0]    current_colcount,
  output logic          frame_done
);

  localparam int HALF_W = IN_WIDTH / 2;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam logic [9:0] LAST_COL = 10'(IN_WIDTH - 1);
  localparam logic [9:0] LAST_ROW = 10'(IN_HEIGHT - 1);

  logic [9:0]    col_r;
  logic [9:0]    row_r;
  logic [7:0]    hold_r;
  logic [8:0]    linebuf [HALF_W];
  logic [8:0]    linebuf_q;

  logic          accept;
  logic [9:0]    col_pos;
  logic [9:0]    row_pos;
  logic [AW-1:0] lb_addr;
  logic [8:0]    pair;
  logic [9:0]    blk_sum;
  logic [7:0]    blk_avg;
  logic          lb_we;
  logic          lb_re;
  logic          blk_done;
  logic          last_blk;

  assign px.ready = ~px.fifo_almost_full;
  assign accept   = px.valid && px.ready;

  // An accepted sof pixel is (0,0) no matter where the counters were, so all
  // per-pixel decisions use this effective position rather than the registers.
  assign col_pos = px.sof ? 10'd0 : col_r;
  assign row_pos = px.sof ? 10'd0 : row_r;

  // Both pixels of a horizontal pair share one line-buffer slot.
  assign lb_addr = col_pos[AW:1];
  assign pair    = {1'b0, hold_r} + {1'b0, px.data};

  assign lb_we    = accept && !row_pos[0] &&  col_pos[0];
  assign lb_re    = accept &&  row_pos[0] && !col_pos[0];
  assign blk_done = accept &&  row_pos[0] &&  col_pos[0];
  assign last_blk = (row_pos == LAST_ROW) && (col_pos == LAST_COL);

  // Max sum is 4*255 = 1020, so +2 still fits in 10 bits and the rounded
  // quotient never exceeds 255.
  assign blk_sum = {1'b0, linebuf_q} + {1'b0, pair};
  assign blk_avg = 8'((blk_sum + 10'd2) >> 2);

  assign current_rowcount = row_r;
  assign current_colcount = col_r;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      col_r         <= '0;
      row_r         <= '0;
      hold_r        <= '0;
      px.fifo_write <= 1'b0;
      px.dataout    <= '0;
      frame_done    <= 1'b0;
    end else begin
      px.fifo_write <= blk_done;
      frame_done    <= blk_done && last_blk;
      if (blk_done) begin
        px.dataout <= blk_avg;
      end
      if (accept) begin
        if (!col_pos[0]) begin
          hold_r <= px.data;
        end
        if (col_pos == LAST_COL) begin
          col_r <= '0;
          row_r <= (row_pos == LAST_ROW) ? 10'd0 : row_pos + 10'd1;
        end else begin
          col_r <= col_pos + 10'd1;
          row_r <= row_pos;
        end
      end
    end
  end

  // Line buffer kept reset-free so it maps onto RAM. The odd-row read is
  // issued on the even column so the data is ready for the odd column,
  // however long the gap between the two pixels.
  always_ff @(posedge clock) begin
    if (lb_we) begin
      linebuf[lb_addr] <= pair;
    end
    if (lb_re) begin
      linebuf_q <= linebuf[lb_addr];
    end
  end

endmodule

// File: tb/tb_downsampler.sv
module tb_downsampler;
  localparam int W  = 24;
  localparam int H  = 12;
  localparam int OW = W / 2;
  localparam int OH = H / 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] rowc;
  logic [9:0] colc;
  logic       frame_done;

  downsampler_if bus();

  downsampler #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .px               (bus),
    .current_rowcount (rowc),
    .current_colcount (colc),
    .frame_done       (frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] d;
    logic       fd;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         ncount = 0;
  int         writes_seen = 0;
  int         fd_seen = 0;
  int         tick = 0;
  logic [7:0] pix [H][W];
  int         mr = 0;
  int         mc = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every negedge, pop the scoreboard when the DUT writes.
  always @(negedge clock) begin
    exp_t e;
    ncount++;
    check("frame_done_without_write", int'(frame_done && !bus.fifo_write), 0);
    if (bus.fifo_write) begin
      writes_seen++;
      if (frame_done) fd_seen++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stray_write got dataout %0d exp no write", bus.dataout);
      end else begin
        e = sbq.pop_front();
        check("dataout", int'(bus.dataout), int'(e.d));
        check("frame_done", int'(frame_done), int'(e.fd));
        check("write_latency", ncount, e.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= ncount) begin
      check("missed_write", int'(bus.fifo_write), 1);
      void'(sbq.pop_front());
    end
  end

  // Reference model: tracks raster position and the pixel array; on each
  // completed 2x2 block the average of the four stored pixels is expected.
  task automatic model_accept(input logic s, input logic [7:0] d);
    int   sum;
    exp_t e;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    pix[mr][mc] = d;
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      sum = int'(pix[mr-1][mc-1]) + int'(pix[mr-1][mc]) +
            int'(pix[mr][mc-1]) + int'(pix[mr][mc]);
      e.d   = 8'((sum + 2) / 4);
      e.fd  = (mr == H - 1) && (mc == W - 1);
      e.due = ncount + 1;
      sbq.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr = (mr + 1) % H;
    end
  endtask

  task automatic step(input logic v, input logic s, input logic [7:0] d,
                      input logic af, output logic acc);
    bus.valid            = v;
    bus.sof              = s;
    bus.data             = d;
    bus.fifo_almost_full = af;
    @(negedge clock);
    check("ready", int'(bus.ready), int'(!af));
    check("colcount", int'(colc), mc);
    check("rowcount", int'(rowc), mr);
    @(posedge clock);
    acc = v && !af;
    if (acc) model_accept(s, d);
    tick++;
    #1;
  endtask

  function automatic logic [7:0] pixgen(input int mode, input int r, input int c);
    int q;
    q = (r % 2) * 2 + (c % 2);
    case (mode)
      0: return 8'd100;
      1: return 8'd255;
      2: return 8'd0;
      3: return (q == 1 || q == 3) ? 8'd1 : 8'd0;
      4: return (q == 0) ? 8'd0 : 8'd1;
      5: return (q == 3) ? 8'd2 : 8'd1;
      6: return (q == 0) ? 8'd1 : 8'd2;
      7: return 8'(c);
      default: return 8'($urandom);
    endcase
  endfunction

  // afmode: 0 never full, 1 random, 2 toggles every 7 cycles.
  task automatic run_frame(input int mode, input int vpct, input int afmode, input int npix);
    for (int i = 0; i < npix; i++) begin
      logic       acc;
      logic [7:0] d;
      logic       v;
      logic       af;
      int         t;
      acc = 1'b0;
      d = (i == 0) ? pixgen(mode, 0, 0) : pixgen(mode, mr, mc);
      t = 0;
      while (!acc && t < 400) begin
        v  = ($urandom_range(99) < vpct);
        af = (afmode == 0) ? 1'b0 :
             (afmode == 1) ? ($urandom_range(99) < 30) : ((tick / 7) % 2 == 1);
        step(v, (i == 0), d, af, acc);
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL stall_timeout got no accept exp accept within 400 cycles");
        return;
      end
    end
  endtask

  task automatic drain(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'b0, acc);
  endtask

  task automatic full_frame(input string name, input int mode, input int vpct, input int afmode);
    int w0;
    int f0;
    w0 = writes_seen;
    f0 = fd_seen;
    run_frame(mode, vpct, afmode, W * H);
    drain(3);
    check({name, "_writes"}, writes_seen - w0, OW * OH);
    check({name, "_frame_done_count"}, fd_seen - f0, 1);
  endtask

  task automatic mid_reset();
    bus.valid = 1'b0;
    bus.sof   = 1'b0;
    reset_n   = 1'b0;
    sbq.delete();
    mr = 0;
    mc = 0;
    #1;
    check("rst_fifo_write", int'(bus.fifo_write), 0);
    check("rst_rowcount", int'(rowc), 0);
    check("rst_colcount", int'(colc), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_dataout", int'(bus.dataout), 0);
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    bus.valid            = 1'b0;
    bus.sof              = 1'b0;
    bus.data             = 8'd0;
    bus.fifo_almost_full = 1'b0;
    #1;
    check("init_fifo_write", int'(bus.fifo_write), 0);
    check("init_dataout", int'(bus.dataout), 0);
    check("init_rowcount", int'(rowc), 0);
    check("init_colcount", int'(colc), 0);
    check("init_frame_done", int'(frame_done), 0);
    check("init_ready", int'(bus.ready), 1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    full_frame("const100", 0, 100, 0);
    full_frame("const255", 1, 100, 0);
    full_frame("const0", 2, 100, 0);
    full_frame("blk_0101", 3, 100, 0);
    full_frame("blk_0111", 4, 100, 0);
    full_frame("blk_1112", 5, 100, 0);
    full_frame("blk_1222", 6, 100, 0);
    full_frame("ramp_gaps", 7, 70, 0);
    full_frame("bp_toggle7", 8, 100, 2);
    full_frame("random", 8, 60, 1);

    // Reset right after an odd/odd accept so a write is in flight.
    run_frame(8, 80, 1, 7 * W + 14);
    mid_reset();
    drain(2);
    full_frame("after_reset", 8, 90, 1);

    // sof injected partway through an odd row.
    run_frame(8, 80, 0, 5 * W + 9);
    full_frame("after_sof", 8, 100, 0);

    drain(5);
    check("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
